bank_access_arbiter: RTL and testbench

//  Shares the NUM_BANKS dual-port 8-bit activation memory banks between two requesters.
//  - Loader: SPI input loader, write-only.
//  - Compute: accelerator datapath, reads and writes.

---
 rtl/bank_access_arbiter_pkg.sv | 23 ++
 rtl/bank_access_arbiter_if.sv | 59 +++++
 rtl/bank_access_arbiter_wr_port_arb.sv | 92 +++++++++
 rtl/bank_access_arbiter.sv | 125 ++++++++++++
 tb/tb_bank_access_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_access_arbiter_pkg.sv
// Shared definitions for the activation-memory bank arbiter: default geometry,
// write-port FSM state encodings and the burst-counter sizing helper.
package bank_access_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 13;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned NUM_BANKS_DEF  = 8;
  localparam int unsigned BANK_W_DEF     = 3;
  localparam int unsigned MAX_BURST_DEF  = 4;
  localparam int unsigned STAT_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_LD = 2'd1,
    ST_OWN_CP = 2'd2
  } wr_state_e;

  // Width of a counter that must hold 0 .. max_burst-1 (at least one bit)
  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return (max_burst > 1) ? int'($clog2(max_burst)) : 1;
  endfunction

endpackage

// File: rtl/bank_access_arbiter_if.sv
// Requester handshakes, bank pins and statistics of the bank access arbiter.
// slave = arbiter side, master = requesters plus memory wrapper side.
interface bank_access_arbiter_if
  import bank_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_BANKS  = NUM_BANKS_DEF,
  parameter int unsigned BANK_W     = BANK_W_DEF
);

  logic                            ld_req;
  logic [BANK_W-1:0]               ld_bank;
  logic [ADDR_WIDTH-1:0]           ld_addr;
  logic [DATA_WIDTH-1:0]           ld_data;
  logic                            ld_gnt;

  logic                            cp_req;
  logic                            cp_we;
  logic [BANK_W-1:0]               cp_bank;
  logic [ADDR_WIDTH-1:0]           cp_addr;
  logic [DATA_WIDTH-1:0]           cp_wdata;
  logic                            cp_gnt;
  logic                            cp_rvalid;
  logic [DATA_WIDTH-1:0]           cp_rdata;

  logic [NUM_BANKS-1:0]            mem_csen;
  logic [NUM_BANKS-1:0]            mem_rdena;
  logic [NUM_BANKS-1:0]            mem_wrenb;
  logic [ADDR_WIDTH-1:0]           mem_addr_a;
  logic [ADDR_WIDTH-1:0]           mem_addr_b;
  logic [DATA_WIDTH-1:0]           mem_data_b;
  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_data_a;

  logic                            err_bank;
  logic [STAT_W-1:0]               stat_ld_wait;
  logic [STAT_W-1:0]               stat_cp_wait;

  modport slave (
    input  ld_req, ld_bank, ld_addr, ld_data,
    output ld_gnt,
    input  cp_req, cp_we, cp_bank, cp_addr, cp_wdata,
    output cp_gnt, cp_rvalid, cp_rdata,
    output mem_csen, mem_rdena, mem_wrenb, mem_addr_a, mem_addr_b, mem_data_b,
    input  mem_data_a,
    output err_bank, stat_ld_wait, stat_cp_wait
  );

  modport master (
    output ld_req, ld_bank, ld_addr, ld_data,
    input  ld_gnt,
    output cp_req, cp_we, cp_bank, cp_addr, cp_wdata,
    input  cp_gnt, cp_rvalid, cp_rdata,
    input  mem_csen, mem_rdena, mem_wrenb, mem_addr_a, mem_addr_b, mem_data_b,
    output mem_data_a,
    input  err_bank, stat_ld_wait, stat_cp_wait
  );

endinterface

// File: rtl/bank_access_arbiter_wr_port_arb.sv
// Write-port (port B) ownership FSM with bounded-burst round-robin between
// loader and compute writes; grants are combinational from state and request.
module bank_access_arbiter_wr_port_arb
  import bank_access_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_wreq,
  input  logic cp_wreq,
  output logic ld_gnt_c,
  output logic cp_wgnt_c
);

  localparam int unsigned CNT_W = burst_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  wr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] base_c;
  logic             serve_ld_c, serve_cp_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pick the writer served this cycle and the burst position it is served at;
  // a handover (idle start or owner dropping req) restarts the burst at 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_gnt_c   = 1'b0;
    cp_wgnt_c  = 1'b0;
    serve_ld_c = 1'b0;
    serve_cp_c = 1'b0;
    base_c     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        base_c = '0;
        if (ld_wreq)      serve_ld_c = 1'b1;
        else if (cp_wreq) serve_cp_c = 1'b1;
      end
      ST_OWN_LD: begin
        if (ld_wreq) serve_ld_c = 1'b1;
        else if (cp_wreq) begin
          serve_cp_c = 1'b1;
          base_c     = '0;
        end
      end
      ST_OWN_CP: begin
        if (cp_wreq) serve_cp_c = 1'b1;
        else if (ld_wreq) begin
          serve_ld_c = 1'b1;
          base_c     = '0;
        end
      end
      default: ;
    endcase

    if (serve_ld_c) begin
      ld_gnt_c = rst_n;
      if (cp_wreq && (base_c == CNT_LAST)) begin
        state_d = ST_OWN_CP;
        cnt_d   = '0;
      end else begin
        state_d = ST_OWN_LD;
        cnt_d   = (base_c == CNT_LAST) ? base_c : base_c + CNT_W'(1);
      end
    end else if (serve_cp_c) begin
      cp_wgnt_c = rst_n;
      if (ld_wreq && (base_c == CNT_LAST)) begin
        state_d = ST_OWN_LD;
        cnt_d   = '0;
      end else begin
        state_d = ST_OWN_CP;
        cnt_d   = (base_c == CNT_LAST) ? base_c : base_c + CNT_W'(1);
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

endmodule

// File: rtl/bank_access_arbiter.sv
// Shares NUM_BANKS dual-port activation banks between the SPI loader and compute.
// Optional macro BANK_ARB_STATS_EN enables the write-wait statistics counters.
module bank_access_arbiter
  import bank_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_BANKS  = NUM_BANKS_DEF,
  parameter int unsigned BANK_W     = BANK_W_DEF,
  parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  bank_access_arbiter_if.slave arb
);

  logic                  ld_gnt_c, cp_wgnt_c;
  logic                  rd_fire_c, ld_fire_c, cp_wfire_c, wr_fire_c;
  logic [BANK_W-1:0]     wr_bank_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NUM_BANKS-1:0]  rd_hit_c, wr_hit_c;
  logic                  rd_oob_c, wr_oob_c;
  logic [NUM_BANKS-1:0]  rd_sel1_q, rd_sel2_q;
  logic                  rd_v1_q, rd_v2_q;
  logic [DATA_WIDTH-1:0] rd_slice_c;

  bank_access_arbiter_wr_port_arb #(
    .MAX_BURST (MAX_BURST)
  ) u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_wreq   (arb.ld_req),
    .cp_wreq   (arb.cp_req & arb.cp_we),
    .ld_gnt_c  (ld_gnt_c),
    .cp_wgnt_c (cp_wgnt_c)
  );

  // Port A is uncontended, so every compute read is accepted immediately
  assign rd_fire_c  = arb.cp_req & ~arb.cp_we & rst_n;
  assign ld_fire_c  = arb.ld_req & ld_gnt_c;
  assign cp_wfire_c = arb.cp_req & arb.cp_we & cp_wgnt_c;
  assign wr_fire_c  = ld_fire_c | cp_wfire_c;

  assign arb.ld_gnt = ld_gnt_c;
  assign arb.cp_gnt = rd_fire_c | cp_wgnt_c;

  assign wr_bank_c = ld_fire_c ? arb.ld_bank : arb.cp_bank;
  assign wr_addr_c = ld_fire_c ? arb.ld_addr : arb.cp_addr;
  assign wr_data_c = ld_fire_c ? arb.ld_data : arb.cp_wdata;

  // Bank decode; a bank index with no matching bank decodes to all zeros
  always_comb begin
    rd_hit_c = '0;
    wr_hit_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_fire_c && (arb.cp_bank == BANK_W'(b))) rd_hit_c[b] = 1'b1;
      if (wr_fire_c && (wr_bank_c == BANK_W'(b)))   wr_hit_c[b] = 1'b1;
    end
  end

  assign rd_oob_c = rd_fire_c && (rd_hit_c == '0);
  assign wr_oob_c = wr_fire_c && (wr_hit_c == '0);

  // Returned word: the bank selected two edges ago, zero for an unmapped bank
  always_comb begin
    rd_slice_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_sel2_q[b]) rd_slice_c = arb.mem_data_a[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb.mem_csen   <= '0;
      arb.mem_rdena  <= '0;
      arb.mem_wrenb  <= '0;
      arb.mem_addr_a <= '0;
      arb.mem_addr_b <= '0;
      arb.mem_data_b <= '0;
      rd_v1_q        <= 1'b0;
      rd_v2_q        <= 1'b0;
      rd_sel1_q      <= '0;
      rd_sel2_q      <= '0;
      arb.cp_rvalid  <= 1'b0;
      arb.cp_rdata   <= '0;
      arb.err_bank   <= 1'b0;
    end else begin
      arb.mem_csen  <= rd_hit_c | wr_hit_c;
      arb.mem_rdena <= rd_hit_c;
      arb.mem_wrenb <= wr_hit_c;
      if (rd_fire_c) arb.mem_addr_a <= arb.cp_addr;
      if (wr_fire_c) begin
        arb.mem_addr_b <= wr_addr_c;
        arb.mem_data_b <= wr_data_c;
      end
      rd_v1_q       <= rd_fire_c;
      rd_sel1_q     <= rd_hit_c;
      rd_v2_q       <= rd_v1_q;
      rd_sel2_q     <= rd_sel1_q;
      arb.cp_rvalid <= rd_v2_q;
      arb.cp_rdata  <= rd_slice_c;
      arb.err_bank  <= arb.err_bank | rd_oob_c | wr_oob_c;
    end
  end

`ifdef BANK_ARB_STATS_EN
  // Saturating count of cycles each writer requested without a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb.stat_ld_wait <= '0;
      arb.stat_cp_wait <= '0;
    end else begin
      if (arb.ld_req && !ld_gnt_c && (arb.stat_ld_wait != '1))
        arb.stat_ld_wait <= arb.stat_ld_wait + STAT_W'(1);
      if (arb.cp_req && arb.cp_we && !cp_wgnt_c && (arb.stat_cp_wait != '1))
        arb.stat_cp_wait <= arb.stat_cp_wait + STAT_W'(1);
    end
  end
`else
  assign arb.stat_ld_wait = '0;
  assign arb.stat_cp_wait = '0;
`endif

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Scoreboard bench for bank_access_arbiter with a behavioural bank model;
// expected read words are queued at acceptance and popped on cp_rvalid.
module tb_bank_access_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int NB    = 8;
  localparam int BW    = 4;
  localparam int MB    = 4;
  localparam int MEM_D = 1 << AW;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rd_exp_t;

  logic clk;
  logic rst_n;

  bank_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_W(BW)) bus ();

  bank_access_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB),
    .BANK_W     (BW),
    .MAX_BURST  (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural banks: synchronous read on rdena, write on wrenb, read-old on collision
  logic [DW-1:0]    bmem [NB][MEM_D];
  logic [NB*DW-1:0] dout_v;
  assign bus.mem_data_a = dout_v;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.mem_rdena[b]) dout_v[b*DW +: DW] <= bmem[b][bus.mem_addr_a];
      if (bus.mem_wrenb[b]) bmem[b][bus.mem_addr_b] <= bus.mem_data_b;
    end
  end

  logic [DW-1:0] ref_mem [NB][MEM_D];
  rd_exp_t       rd_q [$];
  int            n_cmp, n_err, cyc;
  int            exp_ld_wait, exp_cp_wait;
  logic          last_ld_w, last_cp_w;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.ld_req = 1'b0; bus.ld_bank = '0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.cp_req = 1'b0; bus.cp_we = 1'b0; bus.cp_bank = '0; bus.cp_addr = '0; bus.cp_wdata = '0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ld_gnt"},  32'(bus.ld_gnt), 32'd0);
    check_eq({tag, "_cp_gnt"},  32'(bus.cp_gnt), 32'd0);
    check_eq({tag, "_rvalid"},  32'(bus.cp_rvalid), 32'd0);
    check_eq({tag, "_rdata"},   32'(bus.cp_rdata), 32'd0);
    check_eq({tag, "_csen"},    32'(bus.mem_csen), 32'd0);
    check_eq({tag, "_rdena"},   32'(bus.mem_rdena), 32'd0);
    check_eq({tag, "_wrenb"},   32'(bus.mem_wrenb), 32'd0);
    check_eq({tag, "_addr_a"},  32'(bus.mem_addr_a), 32'd0);
    check_eq({tag, "_addr_b"},  32'(bus.mem_addr_b), 32'd0);
    check_eq({tag, "_data_b"},  32'(bus.mem_data_b), 32'd0);
    check_eq({tag, "_err"},     32'(bus.err_bank), 32'd0);
    check_eq({tag, "_st_ld"},   32'(bus.stat_ld_wait), 32'd0);
    check_eq({tag, "_st_cp"},   32'(bus.stat_cp_wait), 32'd0);
  endtask

  // One clock: called at a negedge with inputs already driven; predicts, then checks pins
  task automatic cycle();
    logic          ld_w, cp_w, cp_r;
    logic [NB-1:0] wr_oh, rd_oh;
    logic [BW-1:0] wbank;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    rd_exp_t       e;
    #2;
    ld_w  = bus.ld_req & bus.ld_gnt;
    cp_w  = bus.cp_req & bus.cp_we & bus.cp_gnt;
    cp_r  = bus.cp_req & ~bus.cp_we;
    wr_oh = '0;
    rd_oh = '0;
    waddr = '0; wdata = '0; raddr = '0;
    if (cp_r) check_eq("rd_gnt", 32'(bus.cp_gnt), 32'd1);
    check_eq("wr_excl", 32'(ld_w & cp_w), 32'd0);
    if (bus.ld_req && !bus.ld_gnt) exp_ld_wait++;
    if (bus.cp_req && bus.cp_we && !bus.cp_gnt) exp_cp_wait++;
    if (cp_r) begin
      raddr = bus.cp_addr;
      if (int'(bus.cp_bank) < NB) begin
        rd_oh  = NB'(1) << bus.cp_bank;
        e.data = ref_mem[3'(bus.cp_bank)][bus.cp_addr];
      end else begin
        e.data = '0;
      end
      e.cyc = cyc + 3;
      rd_q.push_back(e);
    end
    if (ld_w || cp_w) begin
      wbank = ld_w ? bus.ld_bank : bus.cp_bank;
      waddr = ld_w ? bus.ld_addr : bus.cp_addr;
      wdata = ld_w ? bus.ld_data : bus.cp_wdata;
      if (int'(wbank) < NB) begin
        wr_oh = NB'(1) << wbank;
        ref_mem[3'(wbank)][waddr] = wdata;
      end
    end
    last_ld_w = ld_w;
    last_cp_w = cp_w;
    @(posedge clk);
    #1;
    cyc++;
    check_eq("wrenb", 32'(bus.mem_wrenb), 32'(wr_oh));
    check_eq("rdena", 32'(bus.mem_rdena), 32'(rd_oh));
    check_eq("csen",  32'(bus.mem_csen),  32'(wr_oh | rd_oh));
    if (ld_w || cp_w) begin
      check_eq("addr_b", 32'(bus.mem_addr_b), 32'(waddr));
      check_eq("data_b", 32'(bus.mem_data_b), 32'(wdata));
    end
    if (cp_r) check_eq("addr_a", 32'(bus.mem_addr_a), 32'(raddr));
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      e = rd_q.pop_front();
      check_eq("rvalid", 32'(bus.cp_rvalid), 32'd1);
      check_eq("rdata",  32'(bus.cp_rdata),  32'(e.data));
    end else if (bus.cp_rvalid) begin
      check_eq("rvalid_extra", 32'(bus.cp_rvalid), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    int k, gnt_seen;
    logic [AW-1:0] ld_a, cp_a;
    n_cmp = 0; n_err = 0; cyc = 0;
    exp_ld_wait = 0; exp_cp_wait = 0;
    last_ld_w = 1'b0; last_cp_w = 1'b0;
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(negedge clk);
    #1 check_zero("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Loader alone writes bank 2 / addr 5, then compute reads it back
    bus.ld_req = 1'b1; bus.ld_bank = 4'd2; bus.ld_addr = 13'd5; bus.ld_data = 8'hA5;
    cycle();
    check_eq("ld_alone_gnt", 32'(last_ld_w), 32'd1);
    check_eq("ld_alone_wrenb", 32'(bus.mem_wrenb), 32'h04);
    set_idle();
    bus.cp_req = 1'b1; bus.cp_we = 1'b0; bus.cp_bank = 4'd2; bus.cp_addr = 13'd5;
    cycle();
    set_idle();
    repeat (3) cycle();
    check_eq("err_clean", 32'(bus.err_bank), 32'd0);

    // Write/read collision returns the old word; the following read sees the new one
    bus.ld_req = 1'b1; bus.ld_bank = 4'd3; bus.ld_addr = 13'd7; bus.ld_data = 8'h11;
    cycle();
    bus.ld_data = 8'h3C;
    bus.cp_req = 1'b1; bus.cp_we = 1'b0; bus.cp_bank = 4'd3; bus.cp_addr = 13'd7;
    cycle();
    bus.ld_req = 1'b0;
    cycle();
    set_idle();
    repeat (3) cycle();

    // Unmapped bank read
    bus.cp_req = 1'b1; bus.cp_we = 1'b0; bus.cp_bank = 4'd9; bus.cp_addr = 13'd0;
    cycle();
    set_idle();
    check_eq("err_set", 32'(bus.err_bank), 32'd1);
    repeat (3) cycle();
    check_eq("err_sticky", 32'(bus.err_bank), 32'd1);

    // Both writers saturate: bursts of MB grants alternate starting with the loader
    ld_a = 13'd100; cp_a = 13'd200; k = 0;
    bus.ld_req = 1'b1; bus.ld_bank = 4'd0; bus.ld_addr = ld_a; bus.ld_data = 8'h5A ^ ld_a[7:0];
    bus.cp_req = 1'b1; bus.cp_we = 1'b1; bus.cp_bank = 4'd1; bus.cp_addr = cp_a; bus.cp_wdata = 8'hC3 ^ cp_a[7:0];
    for (int i = 0; i < 24; i++) begin
      cycle();
      check_eq("burst_any", 32'(last_ld_w | last_cp_w), 32'd1);
      check_eq("burst_owner", 32'(last_cp_w), 32'((k / MB) % 2));
      k++;
      if (last_ld_w) begin
        ld_a++; bus.ld_addr = ld_a; bus.ld_data = 8'h5A ^ ld_a[7:0];
      end
      if (last_cp_w) begin
        cp_a++; bus.cp_addr = cp_a; bus.cp_wdata = 8'hC3 ^ cp_a[7:0];
      end
    end
    set_idle();
    repeat (2) cycle();

    // Reset with two reads in flight: outputs clear at once, no late rvalid
    bus.cp_req = 1'b1; bus.cp_we = 1'b0; bus.cp_bank = 4'd2; bus.cp_addr = 13'd5;
    cycle();
    bus.cp_bank = 4'd3; bus.cp_addr = 13'd7;
    cycle();
    rst_n = 1'b0;
    set_idle();
    #1 check_zero("rst_mid");
    rd_q.delete();
    exp_ld_wait = 0; exp_cp_wait = 0;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    // Loader blocked behind a compute burst
    cp_a = 13'd0;
    bus.cp_req = 1'b1; bus.cp_we = 1'b1; bus.cp_bank = 4'd4; bus.cp_addr = cp_a; bus.cp_wdata = 8'h77;
    cycle();
    cp_a++; bus.cp_addr = cp_a;
    bus.ld_req = 1'b1; bus.ld_bank = 4'd5; bus.ld_addr = 13'd9; bus.ld_data = 8'h99;
    gnt_seen = 0;
    for (int i = 0; i < 10 && gnt_seen == 0; i++) begin
      cycle();
      if (last_ld_w) gnt_seen = 1;
      if (last_cp_w) begin
        cp_a++; bus.cp_addr = cp_a;
      end
    end
    check_eq("ld_gnt_bound", 32'(gnt_seen), 32'd1);
    set_idle();
    cycle();
`ifdef BANK_ARB_STATS_EN
    check_eq("stat_ld_wait", 32'(bus.stat_ld_wait), 32'(exp_ld_wait));
    check_eq("stat_cp_wait", 32'(bus.stat_cp_wait), 32'(exp_cp_wait));
`else
    check_eq("stat_ld_off", 32'(bus.stat_ld_wait), 32'd0);
    check_eq("stat_cp_off", 32'(bus.stat_cp_wait), 32'd0);
`endif
    repeat (3) cycle();
    check_eq("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
